// File: rtl/phys_free_list.sv
// phys_free_list: circular FIFO of free physical register numbers.
//   Pops up to ALLOC_PORTS numbers per cycle for rename and pushes up to
//   FREE_PORTS numbers per cycle reclaimed at commit.
// Ports:
//   clk, async_rst_n   clock, asynchronous active-low reset
//   clk_en             global stall; low freezes all state
//   alloc_req/addr/gnt allocation lanes; grant is all-or-nothing
//   free_en/free_addr  reclaim lanes, packed into the tail in lane order
//   free_count, empty  occupancy
//   overflow_err       sticky: a reclaim would have exceeded CELLS

// Per-lane allocation index: head plus the number of requesting lanes below.
module phys_free_list_lane #(
  parameter int LANE = 0,
  parameter int AW   = 7
) (
  input  logic [LANE:0]  req,
  input  logic [AW-1:0]  head,
  output logic [AW-1:0]  idx
);
  logic [AW-1:0] rank;
  always_comb begin
    rank = '0;
    for (int i = 0; i < LANE; i++) rank = rank + AW'(req[i]);
    // idle lanes just show the head entry
    idx = req[LANE] ? head + rank : head;
  end
endmodule

module phys_free_list #(
  parameter int CELLS           = 128,
  parameter int RESERVED        = 32,
  parameter int ALLOC_PORTS     = 4,
  parameter int FREE_PORTS      = 4,
  parameter int PHYS_ADDR_WIDTH = $clog2(CELLS),
  parameter int COUNT_WIDTH     = $clog2(CELLS+1)
) (
  input  logic                                        clk,
  input  logic                                        async_rst_n,
  input  logic                                        clk_en,
  input  logic [ALLOC_PORTS-1:0]                      alloc_req,
  output logic [ALLOC_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] alloc_addr,
  output logic                                        alloc_gnt,
  input  logic [FREE_PORTS-1:0]                       free_en,
  input  logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]  free_addr,
  output logic [COUNT_WIDTH-1:0]                      free_count,
  output logic                                        empty,
  output logic                                        overflow_err
);
  localparam int AW = PHYS_ADDR_WIDTH;
  localparam int CW = COUNT_WIDTH + 1;  // headroom for count + n_free

  logic [AW-1:0]          entry_q [CELLS];
  logic [AW-1:0]          entry_d [CELLS];
  logic [AW-1:0]          head_q, head_d, tail_q, tail_d, slot;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [CW-1:0]          n_req, n_free, granted, cnt_after;
  logic                   ovf;
  logic [ALLOC_PORTS-1:0][AW-1:0] lane_idx;

  for (genvar k = 0; k < ALLOC_PORTS; k++) begin : g_lane
    phys_free_list_lane #(.LANE(k), .AW(AW)) u_lane (
      .req  (alloc_req[k:0]),
      .head (head_q),
      .idx  (lane_idx[k])
    );
    assign alloc_addr[k] = entry_q[lane_idx[k]];
  end

  assign free_count   = count_q;
  assign empty        = (count_q == '0);
  assign overflow_err = overflow_q;

  always_comb begin
    n_req  = '0;
    n_free = '0;
    for (int k = 0; k < ALLOC_PORTS; k++) n_req  = n_req  + CW'(alloc_req[k]);
    for (int j = 0; j < FREE_PORTS;  j++) n_free = n_free + CW'(free_en[j]);

    // grant uses the pre-update count: reclaims this cycle are not bypassed
    alloc_gnt = clk_en && (n_req != '0) && ({1'b0, count_q} >= n_req);
    granted   = alloc_gnt ? n_req : '0;
    cnt_after = {1'b0, count_q} - granted + n_free;
    ovf       = cnt_after > CW'(CELLS);

    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    entry_d    = entry_q;
    slot       = tail_q;

    if (clk_en) begin
      if (alloc_gnt) head_d = head_q + AW'(n_req);
      if (ovf) begin
        // drop the whole reclaim group, but the grant still retires
        overflow_d = 1'b1;
        count_d    = COUNT_WIDTH'({1'b0, count_q} - granted);
      end else begin
        for (int j = 0; j < FREE_PORTS; j++) begin
          if (free_en[j]) begin
            entry_d[slot] = free_addr[j];
            slot          = slot + 1'b1;
          end
        end
        tail_d  = slot;
        count_d = COUNT_WIDTH'(cnt_after);
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      head_q     <= '0;
      tail_q     <= AW'(CELLS - RESERVED);
      count_q    <= COUNT_WIDTH'(CELLS - RESERVED);
      overflow_q <= 1'b0;
      for (int i = 0; i < CELLS; i++)
        entry_q[i] <= (i < CELLS - RESERVED) ? AW'(RESERVED + i) : '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      entry_q    <= entry_d;
    end
  end
endmodule
